vc_allocator_rr: RTL and testbench

Parametrised virtual-channel allocator for the NoC router, sitting between the input blocks and the switch allocator. Each cycle it matches upstream VCs requesting a downstream VC against free VCs on their target downstream input port. Fairness is round-robin among contending upstream VCs per downstream port, and downstream VC selection is configurable as lowest-free or round-robin. It tracks downstream VC occupancy until the downstream port reports the VC idle.

---
 rtl/noc_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/vc_allocator_rr.sv | 131 +++++++++++++
 tb/tb_vc_allocator_rr.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router types and sizing used by the VC allocator and its bench.
package noc_pkg;
  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;
  localparam int VC_SIZE  = $clog2(VC_NUM);
  localparam int PORT_W   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  typedef logic [PORT_W-1:0] port_t;

  typedef enum logic {
    VC_SEL_LOWEST = 1'b0,
    VC_SEL_RR     = 1'b1
  } vc_select_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr_i, with wrap.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic          grant_valid_o
);

  // Each requester's distance from the pointer; the smallest distance wins.
  always_comb begin
    int best_j;
    int best_d;
    int d;
    int ptr;
    best_j        = 0;
    best_d        = N;
    d             = 0;
    ptr           = int'(ptr_i);
    grant_o       = '0;
    grant_valid_o = 1'b0;
    for (int j = 0; j < N; j++) begin
      d = (j >= ptr) ? (j - ptr) : (j + N - ptr);
      if (req_i[j] && (d < best_d)) begin
        best_d = d;
        best_j = j;
      end
    end
    grant_valid_o = (best_d < N);
    for (int j = 0; j < N; j++) begin
      grant_o[j] = grant_valid_o && (best_j == j);
    end
  end

endmodule

// File: rtl/vc_allocator_rr.sv
// Virtual-channel allocator: per downstream port round-robin among upstream VCs,
// lowest-free or round-robin downstream VC pick, occupancy tracked until idle.
module vc_allocator_rr
  import noc_pkg::*;
#(
  parameter int         PORT_NUM  = noc_pkg::PORT_NUM,
  parameter int         VC_NUM    = noc_pkg::VC_NUM,
  parameter int         VC_SIZE   = $clog2(VC_NUM),
  parameter vc_select_t VC_SELECT = VC_SEL_LOWEST
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]          vc_request_i,
  input  port_t [PORT_NUM-1:0][VC_NUM-1:0]          out_port_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]          idle_downstream_vc_i,
  output logic  [PORT_NUM-1:0][VC_NUM-1:0]          vc_valid_o,
  output logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new_o,
  output logic  [PORT_NUM-1:0][VC_NUM-1:0]          available_o
);

  localparam int REQ_N = PORT_NUM * VC_NUM;
  localparam int ARB_W = $clog2(REQ_N);

  logic [PORT_NUM-1:0][VC_NUM-1:0]  avail_q, avail_d;
  logic [PORT_NUM-1:0][ARB_W-1:0]   arb_ptr_q, arb_ptr_d;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] sel_ptr_q, sel_ptr_d;

  logic [PORT_NUM-1:0][REQ_N-1:0]   win_oh;
  logic [PORT_NUM-1:0]              win_vld;
  logic [PORT_NUM-1:0][ARB_W-1:0]   win_idx;
  logic [PORT_NUM-1:0][VC_NUM-1:0]  pick_oh;
  logic [PORT_NUM-1:0]              pick_vld;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] pick_idx;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] pick_ptr;

  function automatic logic [ARB_W-1:0] req_index(input logic [REQ_N-1:0] oh);
    logic [ARB_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (oh[i]) idx = ARB_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [VC_SIZE-1:0] vc_index(input logic [VC_NUM-1:0] oh);
    logic [VC_SIZE-1:0] idx;
    idx = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      if (oh[i]) idx = VC_SIZE'(i);
    end
    return idx;
  endfunction

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    logic [REQ_N-1:0] elig;

    // pick_vld doubles as "port has a free VC", gating every requester to p.
    for (genvar u = 0; u < PORT_NUM; u++) begin : g_up
      for (genvar w = 0; w < VC_NUM; w++) begin : g_vc
        assign elig[u*VC_NUM+w] = vc_request_i[u][w] && pick_vld[p] &&
                                  (out_port_i[u][w] == port_t'(p));
      end
    end

    rr_arbiter #(.N(REQ_N)) u_req_arb (
      .req_i         (elig),
      .ptr_i         (arb_ptr_q[p]),
      .grant_o       (win_oh[p]),
      .grant_valid_o (win_vld[p])
    );

    assign pick_ptr[p] = (VC_SELECT == VC_SEL_RR) ? sel_ptr_q[p] : '0;

    rr_arbiter #(.N(VC_NUM)) u_vc_pick (
      .req_i         (avail_q[p]),
      .ptr_i         (pick_ptr[p]),
      .grant_o       (pick_oh[p]),
      .grant_valid_o (pick_vld[p])
    );

    assign win_idx[p]  = req_index(win_oh[p]);
    assign pick_idx[p] = vc_index(pick_oh[p]);
  end

  always_comb begin
    vc_valid_o = '0;
    vc_new_o   = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int u = 0; u < PORT_NUM; u++) begin
        for (int w = 0; w < VC_NUM; w++) begin
          if (!rst && win_oh[p][u*VC_NUM+w]) begin
            vc_valid_o[u][w] = 1'b1;
            vc_new_o[u][w]   = pick_idx[p];
          end
        end
      end
    end
  end

  // Release only touches busy VCs and allocation only free ones, so they never collide.
  always_comb begin
    avail_d   = avail_q;
    arb_ptr_d = arb_ptr_q;
    sel_ptr_d = sel_ptr_q;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (!avail_q[p][v] && idle_downstream_vc_i[p][v]) avail_d[p][v] = 1'b1;
      end
      if (win_vld[p]) begin
        avail_d[p]   = avail_d[p] & ~pick_oh[p];
        arb_ptr_d[p] = (win_idx[p] == ARB_W'(REQ_N - 1)) ? '0 : win_idx[p] + 1'b1;
        sel_ptr_d[p] = (pick_idx[p] == VC_SIZE'(VC_NUM - 1)) ? '0 : pick_idx[p] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avail_q   <= '1;
      arb_ptr_q <= '0;
      sel_ptr_q <= '0;
    end else begin
      avail_q   <= avail_d;
      arb_ptr_q <= arb_ptr_d;
      sel_ptr_q <= sel_ptr_d;
    end
  end

  assign available_o = avail_q;

endmodule

// File: tb/tb_vc_allocator_rr.sv
// Directed bench for vc_allocator_rr: cycle table on the lowest-free instance,
// hand sequences for VC round-robin selection and asynchronous reset.
module tb_vc_allocator_rr;
  import noc_pkg::*;

  logic clk;
  logic rst;
  logic  [PORT_NUM-1:0][VC_NUM-1:0] req, idle;
  port_t [PORT_NUM-1:0][VC_NUM-1:0] oport;
  logic  [PORT_NUM-1:0][VC_NUM-1:0] valid_lo, valid_rr, avail_lo, avail_rr;
  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] new_lo, new_rr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [9:0] req;
    port_t      tgt;
    logic [9:0] idle;
    logic [9:0] exp_valid;
    logic [9:0] exp_new;
    logic [9:0] exp_avail;
  } vec_t;

  vec_t vq[$];

  vc_allocator_rr #(.VC_SELECT(VC_SEL_LOWEST)) dut_lo (
    .clk                  (clk),
    .rst                  (rst),
    .vc_request_i         (req),
    .out_port_i           (oport),
    .idle_downstream_vc_i (idle),
    .vc_valid_o           (valid_lo),
    .vc_new_o             (new_lo),
    .available_o          (avail_lo)
  );

  vc_allocator_rr #(.VC_SELECT(VC_SEL_RR)) dut_rr (
    .clk                  (clk),
    .rst                  (rst),
    .vc_request_i         (req),
    .out_port_i           (oport),
    .idle_downstream_vc_i (idle),
    .vc_valid_o           (valid_rr),
    .vc_new_o             (new_rr),
    .available_o          (avail_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %03h expected %03h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] r, input int t, input logic [9:0] i);
    req  = r;
    idle = i;
    for (int u = 0; u < PORT_NUM; u++)
      for (int w = 0; w < VC_NUM; w++)
        oport[u][w] = port_t'(t);
  endtask

  function automatic void add(input logic [9:0] r, input int t, input logic [9:0] i,
                              input logic [9:0] v, input logic [9:0] n, input logic [9:0] a);
    vec_t e;
    e.req = r; e.tgt = port_t'(t); e.idle = i;
    e.exp_valid = v; e.exp_new = n; e.exp_avail = a;
    vq.push_back(e);
  endfunction

  initial begin
    // Reset release, then fill port 2 and release/allocate in the same cycle
    add(10'h001, 2, 10'h000, 10'h001, 10'h000, 10'h3FF);
    add(10'h004, 2, 10'h000, 10'h004, 10'h004, 10'h3EF);
    add(10'h010, 2, 10'h020, 10'h000, 10'h000, 10'h3CF);
    add(10'h010, 2, 10'h000, 10'h010, 10'h010, 10'h3EF);
    add(10'h000, 0, 10'h030, 10'h000, 10'h000, 10'h3CF);
    // Spurious idle everywhere while all VCs are free
    add(10'h000, 0, 10'h3FF, 10'h000, 10'h000, 10'h3FF);
    add(10'h000, 0, 10'h000, 10'h000, 10'h000, 10'h3FF);
    // Contention on port 4: (0,0), (1,1), stall while full, (3,0) after idle
    add(10'h049, 4, 10'h000, 10'h001, 10'h000, 10'h3FF);
    add(10'h048, 4, 10'h000, 10'h008, 10'h008, 10'h2FF);
    add(10'h040, 4, 10'h000, 10'h000, 10'h000, 10'h0FF);
    add(10'h040, 4, 10'h100, 10'h000, 10'h000, 10'h0FF);
    add(10'h040, 4, 10'h000, 10'h040, 10'h000, 10'h1FF);
    add(10'h000, 0, 10'h300, 10'h000, 10'h000, 10'h0FF);
    add(10'h000, 0, 10'h000, 10'h000, 10'h000, 10'h3FF);
    // Fairness on port 1: (0,0) and (2,1) alternate with idle every cycle
    add(10'h021, 1, 10'h00C, 10'h001, 10'h000, 10'h3FF);
    add(10'h021, 1, 10'h00C, 10'h020, 10'h020, 10'h3FB);
    add(10'h021, 1, 10'h00C, 10'h001, 10'h000, 10'h3F7);
    add(10'h021, 1, 10'h00C, 10'h020, 10'h020, 10'h3FB);
    add(10'h021, 1, 10'h00C, 10'h001, 10'h000, 10'h3F7);
    add(10'h021, 1, 10'h00C, 10'h020, 10'h020, 10'h3FB);
    add(10'h000, 0, 10'h00C, 10'h000, 10'h000, 10'h3F7);
    add(10'h000, 0, 10'h000, 10'h000, 10'h000, 10'h3FF);

    rst = 1'b1;
    drive(10'h001, 2, 10'h000);
    #3;
    chk("reset_avail_lo", avail_lo, 10'h3FF);
    chk("reset_avail_rr", avail_rr, 10'h3FF);
    chk("reset_valid_lo", valid_lo, 10'h000);
    chk("reset_valid_rr", valid_rr, 10'h000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].req, int'(vq[i].tgt), vq[i].idle);
      #4;
      chk($sformatf("vec%0d_valid", i), valid_lo, vq[i].exp_valid);
      chk($sformatf("vec%0d_new", i),   new_lo,   vq[i].exp_new);
      chk($sformatf("vec%0d_avail", i), avail_lo, vq[i].exp_avail);
      @(posedge clk);
      #1;
    end

    // Single requester (4,1) to port 3, released the following cycle
    for (int k = 0; k < 4; k++) begin
      drive(10'h200, 3, 10'h000);
      #4;
      chk($sformatf("vcsel%0d_valid_lo", k), valid_lo, 10'h200);
      chk($sformatf("vcsel%0d_valid_rr", k), valid_rr, 10'h200);
      chk($sformatf("vcsel%0d_new_lo", k), 10'(new_lo[4][1]), 10'h000);
      chk($sformatf("vcsel%0d_new_rr", k), 10'(new_rr[4][1]), 10'(k % 2));
      @(posedge clk);
      #1;
      drive(10'h000, 0, 10'h0C0);
      @(posedge clk);
      #1;
    end
    drive(10'h000, 0, 10'h000);
    #4;
    chk("vcsel_avail_lo", avail_lo, 10'h3FF);
    chk("vcsel_avail_rr", avail_rr, 10'h3FF);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-cycle with an allocation outstanding
    drive(10'h001, 0, 10'h000);
    #4;
    chk("mid_first_valid", valid_lo, 10'h001);
    @(posedge clk);
    #1;
    drive(10'h004, 0, 10'h000);
    #2;
    chk("mid_before_avail", avail_lo, 10'h3FE);
    chk("mid_before_valid", valid_lo, 10'h004);
    chk("mid_before_new", new_lo, 10'h004);
    rst = 1'b1;
    #1;
    chk("mid_rst_avail_lo", avail_lo, 10'h3FF);
    chk("mid_rst_avail_rr", avail_rr, 10'h3FF);
    chk("mid_rst_valid_lo", valid_lo, 10'h000);
    chk("mid_rst_valid_rr", valid_rr, 10'h000);
    @(posedge clk);
    #1 rst = 1'b0;
    #3;
    chk("post_rst_valid", valid_lo, 10'h004);
    chk("post_rst_new", new_lo, 10'h000);
    @(posedge clk);
    #1;
    drive(10'h000, 0, 10'h000);
    #3;
    chk("post_rst_avail", avail_lo, 10'h3FE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
